scan_sequencer: RTL

Sequencing controller for the per-channel processing datapath. It measures the mirror scan period from scan-end edge pulses and resolves scan direction. It publishes t_ltr, t_rtl, dir and a sync_start pulse, which all channel processors consume in common. It also supervises lock, glitch rejection and loss-of-scan timeout, so downstream timestamp normalisation only runs on consistent scans.

---
 rtl/scan_seq_pkg.sv | 14 +
 rtl/scan_sequencer_period_tracker.sv | 72 +++++++
 rtl/scan_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/scan_seq_pkg.sv
// Shared types and defaults for the scan sequencer and its period tracker.
package scan_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    ACQUIRE = 2'd2,
    TRACK   = 2'd3
  } scan_state_t;

  localparam int CNT_W_DEFAULT = 32;
  localparam int GLITCH_W      = 8;

endpackage

// File: rtl/scan_sequencer_period_tracker.sv
// Remembers the last LTR/RTL periods, judges each new period against its
// same-direction predecessor and counts consecutive consistent periods.
module period_tracker
  import scan_seq_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int LOCK_COUNT = 4,
  parameter int TOL_SHIFT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             record,
  input  logic             rec_dir,
  input  logic [CNT_W-1:0] period,
  input  logic             invalidate,
  input  logic             clear_count,
  output logic             in_tol,
  output logic             lock_hit
);

  localparam int              LC_W     = $clog2(LOCK_COUNT + 1);
  localparam logic [LC_W-1:0] LOCK_MAX = LC_W'(LOCK_COUNT);

  logic [CNT_W-1:0] prev_ltr;
  logic [CNT_W-1:0] prev_rtl;
  logic [CNT_W-1:0] prev_sel;
  logic [CNT_W-1:0] diff;
  logic             valid_ltr;
  logic             valid_rtl;
  logic             valid_sel;
  logic [LC_W-1:0]  count;
  logic [LC_W-1:0]  count_inc;

  // lock_hit tells the sequencer that this period completes the lock run.
  always_comb begin
    prev_sel  = rec_dir ? prev_rtl : prev_ltr;
    valid_sel = rec_dir ? valid_rtl : valid_ltr;
    diff      = (period >= prev_sel) ? (period - prev_sel) : (prev_sel - period);
    in_tol    = valid_sel && (diff <= (prev_sel >> TOL_SHIFT));
    count_inc = (count == LOCK_MAX) ? count : count + 1'b1;
    lock_hit  = in_tol && (count_inc == LOCK_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_ltr  <= '0;
      prev_rtl  <= '0;
      valid_ltr <= 1'b0;
      valid_rtl <= 1'b0;
      count     <= '0;
    end else begin
      if (invalidate) begin
        valid_ltr <= 1'b0;
        valid_rtl <= 1'b0;
      end else if (record) begin
        if (rec_dir) begin
          prev_rtl  <= period;
          valid_rtl <= 1'b1;
        end else begin
          prev_ltr  <= period;
          valid_ltr <= 1'b1;
        end
      end
      if (clear_count) begin
        count <= '0;
      end else if (record) begin
        count <= in_tol ? count_inc : '0;
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Measures mirror scan periods from scan-end pulses, resolves direction and
// supervises lock, glitch rejection and loss-of-scan for the channel datapath.
module scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int MIN_SCAN   = 1000,
  parameter int TIMEOUT    = 2000000,
  parameter int LOCK_COUNT = 4,
  parameter int TOL_SHIFT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                edge_in,
  input  logic                dir_ref,
  input  logic                err_clr,
  output logic                dir,
  output logic [CNT_W-1:0]    t_ltr,
  output logic [CNT_W-1:0]    t_rtl,
  output logic                sync_start,
  output logic                locked,
  output logic                timeout_err,
  output logic                dir_err,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_SCAN);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  scan_state_t         state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                dir_n;
  logic [CNT_W-1:0]    t_ltr_n, t_rtl_n;
  logic                sync_n, locked_n, tmo_n, dir_err_n;
  logic [GLITCH_W-1:0] glitch_n;
  logic                accept, reject;
  logic                record, invalidate, clear_count;
  logic                in_tol, lock_hit;

  assign accept = edge_in && (state != IDLE) && ((state == ARM) || (cnt >= MIN_C));
  assign reject = edge_in && !accept;

  period_tracker #(
    .CNT_W      (CNT_W),
    .LOCK_COUNT (LOCK_COUNT),
    .TOL_SHIFT  (TOL_SHIFT)
  ) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .record      (record),
    .rec_dir     (dir_ref),
    .period      (cnt),
    .invalidate  (invalidate),
    .clear_count (clear_count),
    .in_tol      (in_tol),
    .lock_hit    (lock_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dir         <= 1'b0;
      t_ltr       <= '0;
      t_rtl       <= '0;
      sync_start  <= 1'b0;
      locked      <= 1'b0;
      timeout_err <= 1'b0;
      dir_err     <= 1'b0;
      glitch_cnt  <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      dir         <= dir_n;
      t_ltr       <= t_ltr_n;
      t_rtl       <= t_rtl_n;
      sync_start  <= sync_n;
      locked      <= locked_n;
      timeout_err <= tmo_n;
      dir_err     <= dir_err_n;
      glitch_cnt  <= glitch_n;
    end
  end

  // The accept cycle counts as cycle 0 of the new scan, so cnt restarts at 1
  // and reads exactly the period when the next edge arrives.
  always_comb begin
    state_n     = state;
    cnt_n       = (cnt == TIMEOUT_C) ? cnt : cnt + 1'b1;
    dir_n       = dir;
    t_ltr_n     = t_ltr;
    t_rtl_n     = t_rtl;
    sync_n      = 1'b0;
    locked_n    = locked;
    tmo_n       = timeout_err;
    dir_err_n   = dir_err;
    glitch_n    = glitch_cnt;
    record      = 1'b0;
    invalidate  = 1'b0;
    clear_count = 1'b0;

    if (err_clr) begin
      tmo_n     = 1'b0;
      dir_err_n = 1'b0;
      glitch_n  = '0;
    end
    if (reject && (glitch_cnt != '1)) begin
      glitch_n = glitch_cnt + 1'b1;
    end

    if (!enable) begin
      state_n     = IDLE;
      cnt_n       = '0;
      locked_n    = 1'b0;
      invalidate  = 1'b1;
      clear_count = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_n = ARM;
          cnt_n   = '0;
        end
        ARM: begin
          if (accept) begin
            dir_n   = ~dir_ref;
            sync_n  = 1'b1;
            cnt_n   = CNT_W'(1);
            state_n = ACQUIRE;
          end
        end
        ACQUIRE, TRACK: begin
          if (accept) begin
            cnt_n  = CNT_W'(1);
            sync_n = 1'b1;
            record = 1'b1;
            if (dir_ref) t_rtl_n = cnt;
            else         t_ltr_n = cnt;
            if (state == ACQUIRE) begin
              dir_n = ~dir_ref;
              if (lock_hit) begin
                locked_n = 1'b1;
                state_n  = TRACK;
              end
            end else if (dir_ref != dir) begin
              dir_err_n   = 1'b1;
              dir_n       = ~dir_ref;
              locked_n    = 1'b0;
              clear_count = 1'b1;
              state_n     = ACQUIRE;
            end else begin
              dir_n = ~dir;
              if (!in_tol) begin
                locked_n = 1'b0;
                state_n  = ACQUIRE;
              end
            end
          end else if (cnt == TIMEOUT_C) begin
            tmo_n       = 1'b1;
            locked_n    = 1'b0;
            invalidate  = 1'b1;
            clear_count = 1'b1;
            state_n     = ARM;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
